// File: rtl/i2c_cmd_master.sv
// ---------------------------------------------------------------------------
// i2c_cmd_master
//
// Write-only I2C master. Each accepted request turns one 16-bit CODEC
// configuration word into a 3-byte I2C write: {SLV_ADDR, W}, data[15:8],
// data[7:0]. A NACK on any byte aborts the remaining bytes and finishes
// with a stop condition.
//
// Parameters
//   SLV_ADDR : 7-bit slave address placed in the first byte (R/W = 0)
//   QTR      : clk cycles per SCL quarter-period (minimum 4)
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   data16 : command word, captured when wrt is accepted
//   wrt    : start strobe, honoured only while idle
//   done   : one-cycle pulse on the last cycle of every transaction
//   err    : NACK seen in the last transaction, sticky until next accept
//   SCL    : I2C clock, push-pull
//   SDA    : I2C data, open-drain (drives 0 or releases)
// ---------------------------------------------------------------------------
module i2c_cmd_master #(
  parameter logic [6:0] SLV_ADDR = 7'h1A,
  parameter int unsigned QTR = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data16,
  input  logic        wrt,
  output logic        done,
  output logic        err,
  output logic        SCL,
  inout  wire         SDA
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP} state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [1:0]    byteCnt_q, byteCnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          nack_q, nack_d;
  logic          err_q, err_d;
  logic          scl_q, scl_d;
  logic          sdaLow_q, sdaLow_d;
  logic          done_q, done_d;
  logic          sdaMeta_q, sdaSync_q;
  logic          tick, slotEnd;

  assign tick    = (qcnt_q == QLAST);
  assign slotEnd = tick && (phase_q == 2'd3);

  // Next-state logic. The bus outputs are decoded from the *next* state and
  // then registered, so SCL/SDA/done come straight from flops and the value
  // seen in a cycle always matches the state/phase of that same cycle.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    nack_d    = nack_q;
    err_d     = err_q;

    if (state_q != IDLE) begin
      qcnt_d = tick ? '0 : qcnt_q + QW'(1);
      if (tick) begin
        phase_d = phase_q + 2'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wrt) begin
          state_d   = START;
          shift_d   = {SLV_ADDR, 1'b0, data16};
          err_d     = 1'b0;
          nack_d    = 1'b0;
          qcnt_d    = '0;
          phase_d   = 2'd0;
          bitCnt_d  = 3'd0;
          byteCnt_d = 2'd0;
        end
      end
      START: begin
        if (slotEnd) begin
          state_d   = BITS;
          bitCnt_d  = 3'd7;
          byteCnt_d = 2'd0;
        end
      end
      BITS: begin
        if (slotEnd) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bitCnt_q == 3'd0) begin
            state_d = ACK;
          end else begin
            bitCnt_d = bitCnt_q - 3'd1;
          end
        end
      end
      ACK: begin
        // Slave response is taken on the last cycle of Q2 (SCL high) but the
        // decision waits for the end of the slot so every byte is 9 slots.
        if (tick && (phase_q == 2'd2)) begin
          nack_d = sdaSync_q;
          if (sdaSync_q) begin
            err_d = 1'b1;
          end
        end
        if (slotEnd) begin
          if (nack_q) begin
            state_d = STOP;
          end else if (byteCnt_q < 2'd2) begin
            state_d   = BITS;
            byteCnt_d = byteCnt_q + 2'd1;
            bitCnt_d  = 3'd7;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (slotEnd) begin
          state_d   = IDLE;
          byteCnt_d = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus waveform per state. STOP raises SCL one quarter early (Q1) so that
  // SDA can rise at Q2 while SCL is already high, forming the stop condition.
  always_comb begin
    scl_d    = 1'b1;
    sdaLow_d = 1'b0;
    unique case (state_d)
      IDLE: begin
        scl_d    = 1'b1;
        sdaLow_d = 1'b0;
      end
      START: begin
        sdaLow_d = phase_d[1];
      end
      BITS: begin
        scl_d    = phase_d[1];
        sdaLow_d = ~shift_d[23];
      end
      ACK: begin
        scl_d = phase_d[1];
      end
      STOP: begin
        scl_d    = (phase_d != 2'd0);
        sdaLow_d = ~phase_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sdaLow_d = 1'b0;
      end
    endcase
    done_d = (state_d == STOP) && (phase_d == 2'd3) && (qcnt_d == QLAST);
  end

  // All state, counters and bus outputs; reset returns the bus to idle at
  // once without generating a stop condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bitCnt_q  <= 3'd0;
      byteCnt_q <= 2'd0;
      shift_q   <= 24'd0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
      scl_q     <= 1'b1;
      sdaLow_q  <= 1'b0;
      done_q    <= 1'b0;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
      scl_q     <= scl_d;
      sdaLow_q  <= sdaLow_d;
      done_q    <= done_d;
      sdaMeta_q <= SDA;
      sdaSync_q <= sdaMeta_q;
    end
  end

  assign SCL  = scl_q;
  assign SDA  = sdaLow_q ? 1'b0 : 1'bz;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: doc/i2c_cmd_master.md
# i2c_cmd_master

Write-only I2C bus master that serialises one 16-bit CODEC configuration word per request into a 3-byte I2C write (slave address + W, data high byte, data low byte). It sits directly downstream of the CODEC configuration sequencer, which supplies `data16` and a one-cycle `wrt` strobe and waits for `done`. It drives the CODEC's SCL line and the open-drain SDA line.

## Interface
- `SLV_ADDR`, default 7'h1A: 7-bit I2C slave address sent in the first byte, with R/W = 0.
- `QTR`, default 125: clk cycles per SCL quarter-period. Minimum 4. The default gives 100 kHz SCL at 50 MHz.

- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `data16`  in  16: command word; captured on an accepted `wrt`.
- `wrt`  in  1: start strobe; honoured only when idle.
- `done`  out  1: single-cycle pulse at the end of every transaction, including aborted ones.
- `err`  out  1: NACK seen in the last transaction; sticky until the next accepted `wrt`.
- `SCL`  out  1: I2C clock, push-pull.
- `SDA`  inout  1: I2C data, open-drain. The block drives 0 or releases to Z; it never drives 1.

## Operation
- States: IDLE, START, BITS, ACK, STOP.
- Each bit slot lasts 4 quarters, Q0–Q3. SCL is 0 in Q0/Q1 and 1 in Q2/Q3. SDA changes only at the start of Q0.
- IDLE
  - SCL = 1, SDA released.
  - `wrt` = 1 captures `shift = {SLV_ADDR,1'b0,data16}` (24 bits), clears `err`, and goes to START.
- START (4 quarters)
  - SDA released with SCL = 1 for Q0–Q1.
  - SDA driven 0 at Q2 while SCL stays 1 (start condition).
  - Then to BITS with byte_cnt = 0 and bit_cnt = 7.
- BITS
  - Sends `shift[23]`, MSB first: 0 → drive low, 1 → release.
  - Shift left at the end of Q3.
  - After bit 0 of the byte, go to ACK.
- ACK
  - SDA released.
  - Sample the synchronised SDA at the last cycle of Q2.
  - Sample 0: if byte_cnt < 2, increment byte_cnt and return to BITS; else go to STOP.
  - Sample 1 (NACK): set `err` and go straight to STOP. The remaining bytes are not sent.
- STOP (4 quarters)
  - SDA driven 0 in Q0–Q1 with SCL 0 then 1.
  - SDA released at Q2 with SCL = 1 (stop condition).
  - At the end of Q3, pulse `done` for 1 cycle and go to IDLE.
- `wrt` while not IDLE is ignored: no queueing and no effect on the current transfer.
- SDA input passes through a 2-flop synchroniser before sampling.
- Counters
  - Quarter counter: 0..QTR-1, wraps.
  - Phase: 2 bits.
  - bit_cnt: 3 bits.
  - byte_cnt: 2 bits, values 0..2 only.

## Timing
- Reset values:
  - SCL = 1, SDA released (Z), `done` = 0, `err` = 0.
  - State IDLE, all counters 0.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronously). No stop condition is generated.
- `wrt` sampled at cycle N (IDLE) → START Q0 begins at N+1.
- Full transaction: (4 + 27·4 + 4)·QTR = 116·QTR cycles from the START Q0 cycle.
- `done` asserts on the final cycle of that span.
- NACK on byte k (k = 0..2) → duration (4 + (k+1)·36 + 4)·QTR.
- `err` becomes valid no later than the cycle `done` pulses. It holds until the cycle after the next accepted `wrt`.
- `wrt` in the same cycle as `done` is ignored, because the block is not yet IDLE. It is accepted from the following cycle onward.

## Test plan
- QTR = 4, SLV_ADDR = 7'h1A, `data16` = 16'h1E00, slave ACKs all bytes:
  - SDA bit stream decoded at SCL rising edges is 0x34, 0x1E, 0x00, with start and stop conditions present.
  - `done` pulses exactly 464 cycles after the first START cycle.
  - `err` = 0.
- Slave NACKs the address byte → no data bytes on the bus, stop issued, `done` after 176 cycles, `err` = 1. The next `wrt` clears `err`.
- `wrt` re-pulsed with `data16` = 16'hFFFF mid-transfer of 16'h0A55 → bus shows 0x0A, 0x55 only, and exactly one `done`.
- `rst_n` low during byte 1 → SCL = 1 and SDA = Z within the same cycle. A fresh `wrt` after release produces a clean transaction.
- Nine back-to-back commands, each issued 1 cycle after the previous `done`:
  - 9 `done` pulses.
  - Each byte sequence matches its `data16`.
  - SDA never changes while SCL = 1 except at start and stop conditions.
